rr_req_agent: RTL and testbench

Requester-side front end for the 4-port round-robin arbiter. It accumulates per-port service events into pending counters and drives req_o into the arbiter. It consumes the arbiter's one-hot gnt_i and runs one valid/ready service transaction per grant toward the shared resource. One transaction is outstanding at a time; all requests are masked while it is in flight.

---
 rtl/rr_req_pkg.sv | 28 ++
 rtl/rr_pend_cnt.sv | 52 +++++
 rtl/rr_req_agent.sv | 131 +++++++++++++
 tb/tb_rr_req_agent.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_req_pkg.sv
// Shared types, default sizes and one-hot helpers for the round-robin requester agent.
package rr_req_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_e;

    localparam int NUM_PORTS_D = 4;
    localparam int CNT_W_D     = 4;

    // A vector is one-hot when it is nonzero and clearing its lowest set bit leaves nothing.
    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

    function automatic int onehot_idx(input logic [31:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pend_cnt.sv
// Saturating up/down pending-request counter with a sticky overflow flag.
module rr_pend_cnt
    import rr_req_pkg::*;
#(
    parameter int CNT_W = CNT_W_D
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    // At saturation a concurrent decrement still applies, since the increment is dropped.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (inc_i && dec_i) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = cnt_q - 1'b1;
            end
        end else if (inc_i) begin
            if (cnt_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/rr_req_agent.sv
// Requester front end for a round-robin arbiter: pending counters, request vector and one
// valid/ready transaction per grant. Optional SERVE timeout via RR_REQ_AGENT_TIMEOUT_EN.
module rr_req_agent
    import rr_req_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_D,
    parameter int CNT_W     = CNT_W_D
`ifdef RR_REQ_AGENT_TIMEOUT_EN
    ,
    parameter int TIMEOUT   = 16
`endif
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_PORTS-1:0]         event_i,
    output logic [NUM_PORTS-1:0]         req_o,
    input  logic [NUM_PORTS-1:0]         gnt_i,
    output logic                         svc_valid_o,
    output logic [$clog2(NUM_PORTS)-1:0] svc_port_o,
    input  logic                         svc_ready_i,
    output logic                         busy_o,
    output logic [NUM_PORTS-1:0]         ovf_o,
    output logic                         gnt_err_o
`ifdef RR_REQ_AGENT_TIMEOUT_EN
    ,
    output logic                         timeout_o
`endif
);

    localparam int IDX_W = $clog2(NUM_PORTS);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   svc_port_q, svc_port_d;
    logic               gnt_err_q, gnt_err_d;
    logic [NUM_PORTS-1:0] dec_vec;
    logic [NUM_PORTS-1:0] nz_vec;
    logic [CNT_W-1:0]   pend_cnt [NUM_PORTS];

`ifdef RR_REQ_AGENT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               timeout_q, timeout_d;
`endif

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_cnt
        rr_pend_cnt #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .reset (reset),
            .inc_i (event_i[p]),
            .dec_i (dec_vec[p]),
            .cnt_o (pend_cnt[p]),
            .ovf_o (ovf_o[p])
        );
        assign nz_vec[p] = (pend_cnt[p] != '0);
    end

    assign req_o = (state_q == IDLE) ? nz_vec : '0;

    // A grant is accepted only in IDLE and only if it is one-hot onto a requesting port.
    always_comb begin
        state_d    = state_q;
        svc_port_d = svc_port_q;
        gnt_err_d  = gnt_err_q;
        dec_vec    = '0;
`ifdef RR_REQ_AGENT_TIMEOUT_EN
        tmo_d      = tmo_q;
        timeout_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
`ifdef RR_REQ_AGENT_TIMEOUT_EN
                tmo_d = '0;
`endif
                if (gnt_i != '0) begin
                    if (is_onehot(32'(gnt_i)) && ((gnt_i & req_o) == gnt_i)) begin
                        svc_port_d = IDX_W'(onehot_idx(32'(gnt_i)));
                        state_d    = SERVE;
                    end else begin
                        gnt_err_d = 1'b1;
                    end
                end
            end
            SERVE: begin
                if (svc_ready_i) begin
                    dec_vec[svc_port_q] = 1'b1;
                    state_d             = IDLE;
                end
`ifdef RR_REQ_AGENT_TIMEOUT_EN
                else begin
                    tmo_d = tmo_q + 1'b1;
                    if (tmo_d == TMO_W'(TIMEOUT)) begin
                        state_d   = IDLE;
                        timeout_d = 1'b1;
                    end
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            svc_port_q <= '0;
            gnt_err_q  <= 1'b0;
`ifdef RR_REQ_AGENT_TIMEOUT_EN
            tmo_q      <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            svc_port_q <= svc_port_d;
            gnt_err_q  <= gnt_err_d;
`ifdef RR_REQ_AGENT_TIMEOUT_EN
            tmo_q      <= tmo_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign svc_valid_o = (state_q == SERVE);
    assign busy_o      = (state_q == SERVE);
    assign svc_port_o  = svc_port_q;
    assign gnt_err_o   = gnt_err_q;
`ifdef RR_REQ_AGENT_TIMEOUT_EN
    assign timeout_o   = timeout_q;
`endif

endmodule

// File: tb/tb_rr_req_agent.sv
// Directed bench for rr_req_agent with a small round-robin arbiter model and a grant override.
module tb_rr_req_agent;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] event_i;
    logic [3:0] req_o;
    logic [3:0] gnt_i;
    logic       svc_valid_o;
    logic [1:0] svc_port_o;
    logic       svc_ready_i;
    logic       busy_o;
    logic [3:0] ovf_o;
    logic       gnt_err_o;
`ifdef RR_REQ_AGENT_TIMEOUT_EN
    logic       timeout_o;
`endif

    int checks = 0;
    int errors = 0;

    logic       force_en;
    logic [3:0] force_gnt;
    logic [3:0] arb_gnt;
    logic [1:0] arb_idx;
    logic [1:0] rr_ptr;

    always #5 clk = ~clk;

    rr_req_agent dut (
        .clk         (clk),
        .reset       (reset),
        .event_i     (event_i),
        .req_o       (req_o),
        .gnt_i       (gnt_i),
        .svc_valid_o (svc_valid_o),
        .svc_port_o  (svc_port_o),
        .svc_ready_i (svc_ready_i),
        .busy_o      (busy_o),
        .ovf_o       (ovf_o),
        .gnt_err_o   (gnt_err_o)
`ifdef RR_REQ_AGENT_TIMEOUT_EN
        ,
        .timeout_o   (timeout_o)
`endif
    );

    // Arbiter model: first requester at or after the pointer wins; pointer moves past the winner.
    always_comb begin
        arb_gnt = 4'b0000;
        arb_idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] cand;
            cand = 2'(rr_ptr + k);
            if (req_o[cand] && (arb_gnt == 4'b0000)) begin
                arb_gnt[cand] = 1'b1;
                arb_idx       = cand;
            end
        end
    end

    assign gnt_i = force_en ? force_gnt : arb_gnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= 2'd0;
        end else if (!force_en && (arb_gnt != 4'b0000) && !busy_o) begin
            rr_ptr <= arb_idx + 2'd1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] ev, input logic rdy,
                                 input logic fen, input logic [3:0] fgnt);
        event_i     = ev;
        svc_ready_i = rdy;
        force_en    = fen;
        force_gnt   = fgnt;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(4'b0000, 1'b1, 1'b0, 4'b0000);
        tick();
        tick();
        reset = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_req", 32'(req_o), 32'h0);
        checkOutput("rst_valid", 32'(svc_valid_o), 32'h0);
        checkOutput("rst_busy", 32'(busy_o), 32'h0);
        checkOutput("rst_port", 32'(svc_port_o), 32'h0);
        checkOutput("rst_ovf", 32'(ovf_o), 32'h0);
        checkOutput("rst_gnt_err", 32'(gnt_err_o), 32'h0);

        $display("[TB] single event on port 2");
        applyStimulus(4'b0100, 1'b1, 1'b0, 4'b0000);
        tick();
        event_i = 4'b0000;
        checkOutput("t1_req", 32'(req_o), 32'h4);
        checkOutput("t1_valid_idle", 32'(svc_valid_o), 32'h0);
        checkOutput("t1_cnt2_one", 32'(dut.pend_cnt[2]), 32'h1);
        tick();
        checkOutput("t1_busy", 32'(busy_o), 32'h1);
        checkOutput("t1_valid", 32'(svc_valid_o), 32'h1);
        checkOutput("t1_port", 32'(svc_port_o), 32'h2);
        checkOutput("t1_req_masked", 32'(req_o), 32'h0);
        tick();
        checkOutput("t1_idle", 32'(busy_o), 32'h0);
        checkOutput("t1_req_done", 32'(req_o), 32'h0);
        checkOutput("t1_cnt2_zero", 32'(dut.pend_cnt[2]), 32'h0);

        $display("[TB] all four ports once");
        doReset();
        applyStimulus(4'b1111, 1'b1, 1'b0, 4'b0000);
        tick();
        event_i = 4'b0000;
        checkOutput("t2_req_all", 32'(req_o), 32'hf);
        for (int p = 0; p < 4; p++) begin
            tick();
            checkOutput($sformatf("t2_valid%0d", p), 32'(svc_valid_o), 32'h1);
            checkOutput($sformatf("t2_port%0d", p), 32'(svc_port_o), 32'(p));
            tick();
            checkOutput($sformatf("t2_gap%0d", p), 32'(busy_o), 32'h0);
        end
        for (int p = 0; p < 4; p++) begin
            checkOutput($sformatf("t2_cnt%0d_zero", p), 32'(dut.pend_cnt[p]), 32'h0);
        end
        checkOutput("t2_req_end", 32'(req_o), 32'h0);

        $display("[TB] backpressure for five cycles");
        doReset();
        applyStimulus(4'b0001, 1'b0, 1'b0, 4'b0000);
        tick();
        event_i = 4'b0000;
        tick();
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("t3_valid_hold%0d", i), 32'(svc_valid_o), 32'h1);
            checkOutput($sformatf("t3_port_hold%0d", i), 32'(svc_port_o), 32'h0);
            checkOutput($sformatf("t3_req_hold%0d", i), 32'(req_o), 32'h0);
            tick();
        end
        checkOutput("t3_valid_6th", 32'(svc_valid_o), 32'h1);
        svc_ready_i = 1'b1;
        tick();
        checkOutput("t3_done_idle", 32'(busy_o), 32'h0);
        checkOutput("t3_cnt0_zero", 32'(dut.pend_cnt[0]), 32'h0);

        $display("[TB] saturation and overflow on port 1");
        doReset();
        applyStimulus(4'b0000, 1'b0, 1'b1, 4'b0000);
        for (int i = 0; i < 15; i++) begin
            event_i = 4'b0010;
            tick();
            event_i = 4'b0000;
            tick();
        end
        checkOutput("t4_cnt1_max", 32'(dut.pend_cnt[1]), 32'hf);
        checkOutput("t4_ovf_clear", 32'(ovf_o), 32'h0);
        force_en = 1'b0;
        tick();
        checkOutput("t4_serve1", 32'(svc_port_o), 32'h1);
        applyStimulus(4'b0010, 1'b1, 1'b1, 4'b0000);
        tick();
        event_i     = 4'b0000;
        svc_ready_i = 1'b0;
        checkOutput("t4_inc_dec_max", 32'(dut.pend_cnt[1]), 32'he);
        checkOutput("t4_inc_dec_no_ovf", 32'(ovf_o), 32'h0);
        checkOutput("t4_back_idle", 32'(busy_o), 32'h0);
        for (int i = 0; i < 2; i++) begin
            event_i = 4'b0010;
            tick();
            event_i = 4'b0000;
            tick();
        end
        checkOutput("t4_cnt1_hold", 32'(dut.pend_cnt[1]), 32'hf);
        checkOutput("t4_ovf_set", 32'(ovf_o), 32'h2);

        $display("[TB] illegal grants");
        force_gnt = 4'b0011;
        tick();
        force_gnt = 4'b0000;
        checkOutput("t5_multi_err", 32'(gnt_err_o), 32'h1);
        checkOutput("t5_multi_idle", 32'(busy_o), 32'h0);
        checkOutput("t5_multi_cnt1", 32'(dut.pend_cnt[1]), 32'hf);
        checkOutput("t5_multi_cnt0", 32'(dut.pend_cnt[0]), 32'h0);

        doReset();
        applyStimulus(4'b1000, 1'b0, 1'b1, 4'b0000);
        tick();
        event_i  = 4'b0000;
        force_en = 1'b0;
        tick();
        checkOutput("t5_serve3", 32'(svc_port_o), 32'h3);
        applyStimulus(4'b0000, 1'b0, 1'b1, 4'b1111);
        tick();
        checkOutput("t5_serve_gnt_ignored", 32'(gnt_err_o), 32'h0);
        checkOutput("t5_serve_still_busy", 32'(busy_o), 32'h1);
        applyStimulus(4'b0000, 1'b1, 1'b1, 4'b0000);
        tick();
        checkOutput("t5_cnt3_zero", 32'(dut.pend_cnt[3]), 32'h0);
        applyStimulus(4'b1000, 1'b0, 1'b1, 4'b0000);
        tick();
        event_i   = 4'b0000;
        force_gnt = 4'b0100;
        tick();
        force_gnt = 4'b0000;
        checkOutput("t5_nonreq_err", 32'(gnt_err_o), 32'h1);
        checkOutput("t5_nonreq_idle", 32'(busy_o), 32'h0);
        checkOutput("t5_nonreq_cnt3", 32'(dut.pend_cnt[3]), 32'h1);
        checkOutput("t5_nonreq_cnt2", 32'(dut.pend_cnt[2]), 32'h0);

`ifdef RR_REQ_AGENT_TIMEOUT_EN
        $display("[TB] SERVE timeout and mid-SERVE reset");
        doReset();
        applyStimulus(4'b0001, 1'b0, 1'b1, 4'b0000);
        tick();
        event_i  = 4'b0000;
        force_en = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("t6_busy%0d", i), 32'(busy_o), 32'h1);
            checkOutput($sformatf("t6_no_tmo%0d", i), 32'(timeout_o), 32'h0);
            tick();
        end
        checkOutput("t6_tmo_pulse", 32'(timeout_o), 32'h1);
        checkOutput("t6_tmo_idle", 32'(busy_o), 32'h0);
        checkOutput("t6_tmo_cnt0", 32'(dut.pend_cnt[0]), 32'h1);
        checkOutput("t6_tmo_rereq", 32'(req_o), 32'h1);
        tick();
        checkOutput("t6_tmo_single", 32'(timeout_o), 32'h0);
        checkOutput("t6_reserve", 32'(busy_o), 32'h1);
        reset = 1'b1;
        tick();
        checkOutput("t6_rst_busy", 32'(busy_o), 32'h0);
        checkOutput("t6_rst_cnt0", 32'(dut.pend_cnt[0]), 32'h0);
        checkOutput("t6_rst_port", 32'(svc_port_o), 32'h0);
        reset = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
